// File: rtl/dcp_mem_responder_if.sv
// rtl/dcp_mem_responder_if.sv - request/response bundle between a memory requester and the responder
interface dcp_mem_responder_if #(
    parameter int PADDR_W = 40,
    parameter int DATA_W  = 512
);
    logic               mem_req_val;
    logic               mem_req_rdy;
    logic [5:0]         mem_req_transid;
    logic [PADDR_W-1:0] mem_req_addr;
    logic               mem_resp_val;
    logic [5:0]         mem_resp_transid;
    logic [DATA_W-1:0]  mem_resp_data;

    modport master (
        output mem_req_val, mem_req_transid, mem_req_addr,
        input  mem_req_rdy, mem_resp_val, mem_resp_transid, mem_resp_data
    );

    modport slave (
        input  mem_req_val, mem_req_transid, mem_req_addr,
        output mem_req_rdy, mem_resp_val, mem_resp_transid, mem_resp_data
    );
endinterface

// File: rtl/dcp_mem_responder.sv
// rtl/dcp_mem_responder.sv - fixed-latency in-order line-read responder with preloadable backing store
module dcp_mem_responder #(
    parameter int DEPTH     = 8,
    parameter int LATENCY   = 4,
    parameter int MEM_LINES = 64,
    parameter int PADDR_W   = 40,
    parameter int DATA_W    = 512,
    localparam int IDX_W    = $clog2(MEM_LINES),
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dcp_mem_responder_if.slave   mem,
    input  logic                 init_we,
    input  logic [IDX_W-1:0]     init_idx,
    input  logic [DATA_W-1:0]    init_data,
    output logic [CNT_W-1:0]     outstanding,
    output logic                 err_dup_transid
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CD_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    // Backing store (never reset) and per-slot request state
    logic [DATA_W-1:0] r_mem [MEM_LINES];
    logic [5:0]        r_tid [DEPTH];
    logic [IDX_W-1:0]  r_idx [DEPTH];
    logic [CD_W-1:0]   r_cd  [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_rdy;
    logic              r_resp_val;
    logic [5:0]        r_resp_tid;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_err;

    logic              w_push;
    logic              w_pop;
    logic              w_dup;
    logic [CNT_W-1:0]  w_count_next;
    logic              w_addr_unused;

    function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_push       = mem.mem_req_val && r_rdy;
    assign w_pop        = r_vld[r_rd_ptr] && (r_cd[r_rd_ptr] == '0);
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // Only the line-index bits of the address select a line; offset and upper bits alias away
    assign w_addr_unused = ^{mem.mem_req_addr[5:0], mem.mem_req_addr[PADDR_W-1:6+IDX_W]};

    // Flag a new tag that collides with any entry still waiting (the one leaving this cycle is exempt)
    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_tid[i] == mem.mem_req_transid) &&
                !(w_pop && (PTR_W'(i) == r_rd_ptr))) begin
                w_dup = 1'b1;
            end
        end
    end

    // Preload port; reads for responses see the pre-write contents on a same-edge collision
    always_ff @(posedge clk) begin
        if (init_we) begin
            r_mem[init_idx] <= init_data;
        end
    end

    // Request FIFO with per-entry countdown, registered response and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld       <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_rdy       <= 1'b0;
            r_resp_val  <= 1'b0;
            r_resp_tid  <= '0;
            r_resp_data <= '0;
            r_err       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tid[i] <= '0;
                r_idx[i] <= '0;
                r_cd[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_vld[i] && (r_cd[i] != '0)) begin
                    r_cd[i] <= r_cd[i] - CD_W'(1);
                end
            end
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= f_next(r_rd_ptr);
            end
            if (w_push) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_tid[r_wr_ptr] <= mem.mem_req_transid;
                r_idx[r_wr_ptr] <= mem.mem_req_addr[6 +: IDX_W];
                r_cd[r_wr_ptr]  <= CD_W'(LATENCY - 1);
                r_wr_ptr        <= f_next(r_wr_ptr);
                if (w_dup) begin
                    r_err <= 1'b1;
                end
            end
            r_count     <= w_count_next;
            r_rdy       <= (w_count_next < CNT_W'(DEPTH));
            r_resp_val  <= w_pop;
            r_resp_tid  <= w_pop ? r_tid[r_rd_ptr] : '0;
            r_resp_data <= w_pop ? r_mem[r_idx[r_rd_ptr]] : '0;
        end
    end

    assign mem.mem_req_rdy      = r_rdy;
    assign mem.mem_resp_val     = r_resp_val;
    assign mem.mem_resp_transid = r_resp_tid;
    assign mem.mem_resp_data    = r_resp_data;
    assign outstanding          = r_count;
    assign err_dup_transid      = r_err;
endmodule

// File: tb/tb_dcp_mem_responder.sv
// tb/tb_dcp_mem_responder.sv - scoreboard bench for dcp_mem_responder
module tb_dcp_mem_responder;
    localparam int L1 = 4;

    typedef struct {
        logic [5:0]   tid;
        logic [511:0] data;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   max_out2 = 0;

    logic         init_we = 1'b0;
    logic [5:0]   init_idx = '0;
    logic [511:0] init_data = '0;
    logic [3:0]   outstanding;
    logic         err_dup;

    logic         init2_we = 1'b0;
    logic [5:0]   init2_idx = '0;
    logic [511:0] init2_data = '0;
    logic [1:0]   outstanding2;
    logic         err_dup2;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1;
    exp_t e2;

    dcp_mem_responder_if #(.PADDR_W(40), .DATA_W(512)) i1();
    dcp_mem_responder_if #(.PADDR_W(40), .DATA_W(512)) i2();

    dcp_mem_responder #(.DEPTH(8), .LATENCY(4), .MEM_LINES(64), .PADDR_W(40), .DATA_W(512)) u_dut (
        .clk(clk), .rst_n(rst_n), .mem(i1),
        .init_we(init_we), .init_idx(init_idx), .init_data(init_data),
        .outstanding(outstanding), .err_dup_transid(err_dup)
    );

    dcp_mem_responder #(.DEPTH(2), .LATENCY(8), .MEM_LINES(64), .PADDR_W(40), .DATA_W(512)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .mem(i2),
        .init_we(init2_we), .init_idx(init2_idx), .init_data(init2_data),
        .outstanding(outstanding2), .err_dup_transid(err_dup2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [511:0] pat(input int i);
        logic [31:0] w;
        w = 32'hC0DE0000 + 32'(i);
        return {16{w}};
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load1(input int idx, input logic [511:0] d);
        init_we = 1'b1; init_idx = 6'(idx); init_data = d;
        @(posedge clk); #1;
        init_we = 1'b0;
    endtask

    // Issue one request to the main DUT; exp_cyc < 0 means "LATENCY after the actual accept"
    task automatic send(input logic [5:0] tid, input logic [39:0] addr, input logic [511:0] d, input int exp_cyc);
        exp_t e;
        int w;
        w = 0;
        i1.mem_req_val = 1'b1; i1.mem_req_transid = tid; i1.mem_req_addr = addr;
        while (!i1.mem_req_rdy && w < 100) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 100) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout: got no rdy in %0d cycles, expected rdy", w);
        end
        @(posedge clk); #1;
        e.tid = tid; e.data = d; e.cyc = (exp_cyc < 0) ? cyc + L1 : exp_cyc;
        q1.push_back(e);
        i1.mem_req_val = 1'b0;
    endtask

    task automatic wait_empty1();
        for (int w = 0; w < 200 && q1.size() != 0; w++) @(posedge clk);
        @(posedge clk); #1;
        check("q1_drained", 512'(q1.size()), 512'd0);
    endtask

    // Scoreboard monitors: every presented response must match the next expectation in order and time
    always @(negedge clk) begin
        if (rst_n && i1.mem_resp_val) begin
            vectors++;
            if (q1.size() == 0) begin
                miscompares++;
                $display("FAIL resp1_unexpected: got transid %0d, expected no response", i1.mem_resp_transid);
            end else begin
                e1 = q1.pop_front();
                if (i1.mem_resp_transid !== e1.tid || i1.mem_resp_data !== e1.data || cyc != e1.cyc) begin
                    miscompares++;
                    $display("FAIL resp1: got transid %0d cycle %0d data %0h, expected transid %0d cycle %0d data %0h",
                             i1.mem_resp_transid, cyc, i1.mem_resp_data, e1.tid, e1.cyc, e1.data);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && int'(outstanding2) > max_out2) max_out2 = int'(outstanding2);
        if (rst_n && i2.mem_resp_val) begin
            vectors++;
            if (q2.size() == 0) begin
                miscompares++;
                $display("FAIL resp2_unexpected: got transid %0d, expected no response", i2.mem_resp_transid);
            end else begin
                e2 = q2.pop_front();
                if (i2.mem_resp_transid !== e2.tid || i2.mem_resp_data !== e2.data || cyc != e2.cyc) begin
                    miscompares++;
                    $display("FAIL resp2: got transid %0d cycle %0d data %0h, expected transid %0d cycle %0d data %0h",
                             i2.mem_resp_transid, cyc, i2.mem_resp_data, e2.tid, e2.cyc, e2.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1);
    end

    initial begin
        int t0;
        int n;
        logic acc;
        exp_t e;
        i1.mem_req_val = 1'b0; i1.mem_req_transid = '0; i1.mem_req_addr = '0;
        i2.mem_req_val = 1'b0; i2.mem_req_transid = '0; i2.mem_req_addr = '0;

        // Reset values
        repeat (2) @(posedge clk); #1;
        check("rst_rdy", 512'(i1.mem_req_rdy), 512'd0);
        check("rst_resp_val", 512'(i1.mem_resp_val), 512'd0);
        check("rst_resp_data", i1.mem_resp_data, 512'd0);
        check("rst_outstanding", 512'(outstanding), 512'd0);
        check("rst_err", 512'(err_dup), 512'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rdy_after_release", 512'(i1.mem_req_rdy), 512'd1);

        // Single request to line 3
        load1(3, {64{8'hA5}});
        send(6'd5, 40'hC0, {64{8'hA5}}, -1);
        check("out_after_accept", 512'(outstanding), 512'd1);
        wait_empty1();
        check("out_drained", 512'(outstanding), 512'd0);

        // Back-to-back 0..15, each expected exactly LATENCY after its slot in an unbroken stream
        for (int i = 0; i < 16; i++) load1(i, pat(i));
        t0 = cyc + 1;
        for (int i = 0; i < 16; i++) send(6'(i), 40'(i) << 6, pat(i), t0 + i + L1);
        wait_empty1();
        check("b2b_no_dup", 512'(err_dup), 512'd0);

        // Read-before-write collision on line 7
        load1(7, 512'h0);
        send(6'd1, 40'(7) << 6, 512'h0, -1);
        repeat (3) @(posedge clk);
        #1; init_we = 1'b1; init_idx = 6'd7; init_data = 512'h1;
        @(posedge clk); #1; init_we = 1'b0;
        wait_empty1();
        send(6'd2, 40'(7) << 6, 512'h1, -1);
        wait_empty1();

        // Duplicate transid 9 (second request hits line 4 through address aliasing)
        send(6'd9, 40'(2) << 6, pat(2), -1);
        check("dup_first", 512'(err_dup), 512'd0);
        send(6'd9, 40'(68) << 6, pat(4), -1);
        check("dup_second", 512'(err_dup), 512'd1);
        wait_empty1();
        send(6'd9, 40'(2) << 6, pat(2), -1);
        wait_empty1();
        check("dup_sticky", 512'(err_dup), 512'd1);

        // Async reset with three requests in flight
        send(6'd10, 40'(10) << 6, pat(10), -1);
        send(6'd11, 40'(11) << 6, pat(11), -1);
        send(6'd12, 40'(12) << 6, pat(12), -1);
        check("inflight_out", 512'(outstanding), 512'd3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rdy", 512'(i1.mem_req_rdy), 512'd0);
        check("async_out", 512'(outstanding), 512'd0);
        check("async_err", 512'(err_dup), 512'd0);
        check("async_resp_val", 512'(i1.mem_resp_val), 512'd0);
        check("async_resp_tid", 512'(i1.mem_resp_transid), 512'd0);
        q1.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rdy_after_rerelease", 512'(i1.mem_req_rdy), 512'd1);
        repeat (12) @(posedge clk);
        #1;
        check("no_stale_out", 512'(outstanding), 512'd0);

        // DEPTH=2, LATENCY=8 throughput: accepts at offsets 0,1,9,10 -> responses at 8,9,17,18
        for (int i = 0; i < 4; i++) begin
            init2_we = 1'b1; init2_idx = 6'(i); init2_data = pat(i);
            @(posedge clk); #1;
        end
        init2_we = 1'b0;
        t0 = cyc + 1;
        e.tid = 6'd0; e.data = pat(0); e.cyc = t0 + 8;  q2.push_back(e);
        e.tid = 6'd1; e.data = pat(1); e.cyc = t0 + 9;  q2.push_back(e);
        e.tid = 6'd2; e.data = pat(2); e.cyc = t0 + 17; q2.push_back(e);
        e.tid = 6'd3; e.data = pat(3); e.cyc = t0 + 18; q2.push_back(e);
        n = 0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            i2.mem_req_val = 1'b1; i2.mem_req_transid = 6'(n); i2.mem_req_addr = 40'(n) << 6;
            acc = i2.mem_req_rdy;
            @(posedge clk); #1;
            if (acc) n++;
        end
        i2.mem_req_val = 1'b0;
        check("thr_accepts", 512'(n), 512'd4);
        for (int w = 0; w < 100 && q2.size() != 0; w++) @(posedge clk);
        @(posedge clk); #1;
        check("q2_drained", 512'(q2.size()), 512'd0);
        check("thr_max_out", 512'(max_out2), 512'd2);
        check("thr_out_end", 512'(outstanding2), 512'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
